// File: rtl/niosii_debug_pkg.sv
// Shared definitions for the Nios II debug memory-access engine: FSM states,
// default watchdog limit and the bit positions of fields inside the jdo word.
package niosii_debug_pkg;

  localparam int DEF_TIMEOUT = 255;
  localparam int JDO_W       = 38;
  localparam int ADDR_LSB    = 17;
  localparam int DATA_LSB    = 3;
  localparam int RDEN_BIT    = 35;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CMD  = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR_CMD  = 2'd3
  } state_e;

endpackage

// File: rtl/niosii_debug_watchdog.sv
// Per-state cycle counter: expired fires on the TIMEOUT-th cycle spent in a
// busy state, so no busy state ever lasts longer than TIMEOUT cycles.
module niosii_debug_watchdog
  import niosii_debug_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                 cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/niosii_debug_mem_access.sv
// Debug-slave memory engine: turns one-cycle jdo command pulses into single
// Avalon-MM reads/writes of the debug RAM, with a watchdog and sticky error.
module niosii_debug_mem_access
  import niosii_debug_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              idle, any_pulse, expired;
  logic              jdo_unused;

  assign idle       = (state_q == ST_IDLE);
  assign any_pulse  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign jdo_unused = ^{jdo[JDO_W-1:RDEN_BIT+1], jdo[DATA_LSB-1:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mon_d   = mon_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_LSB +: ADDR_W];
          // clears the sticky flag unless a lower-priority pulse is being dropped
          err_d  = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[RDEN_BIT]) state_d = ST_RD_CMD;
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[DATA_LSB +: 32];
          err_d   = err_q | take_no_action_ocimem_a;
          state_d = ST_WR_CMD;
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_RD_CMD;
        end
      end
      ST_RD_CMD: begin
        if (!avm_waitrequest) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (avm_readdatavalid) begin
          mon_d   = avm_readdata;
          addr_d  = addr_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_CMD: begin
        if (!avm_waitrequest) begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!idle && any_pulse) err_d = 1'b1;

    // a handshake completing in the expiry cycle still counts as success
    if (expired && (state_d == state_q)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  niosii_debug_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (!idle),
    .expired (expired)
  );

  assign avm_address   = addr_q;
  assign avm_read      = (state_q == ST_RD_CMD);
  assign avm_write     = (state_q == ST_WR_CMD);
  assign avm_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = idle;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_niosii_debug_mem_access.sv
// Randomized scoreboard bench: a behavioural RAM/address model predicts each
// command's outcome; a monitor compares whenever the engine returns to ready.
module tb_niosii_debug_mem_access;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          ta_a = 1'b0, ta_b = 1'b0, tna = 1'b0;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata = '0;
  logic          avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;

  niosii_debug_mem_access dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b),
    .take_no_action_ocimem_a(tna),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] mon; logic [AW-1:0] addr; logic err; } res_t;
  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;

  res_t rq[$];
  wr_t  wq[$];
  int   checks = 0, failures = 0;

  logic [31:0]   mem [256];
  logic [31:0]   ref_mem [256];
  logic [31:0]   ref_mon = '0;
  logic [AW-1:0] ref_addr = '0;
  logic          ref_err = 1'b0;

  int forced_wait = -1, forced_lat = -1;
  bit stuck = 1'b0, spur_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- Avalon slave: RAM with random waits / latency ----------
  initial begin
    bit p_rd = 0, p_wr = 0, p_wait = 0, pend = 0, in_txn = 0, w;
    logic [AW-1:0] p_addr = '0;
    logic [31:0] p_wdata = '0, pend_data = '0;
    int pend_lat = 0, wleft = 0;
    forever begin
      @(posedge clk); #2;
      if ((p_rd || p_wr) && !p_wait) begin
        in_txn = 0;
        if (p_rd) begin
          pend = 1; pend_data = mem[p_addr];
          pend_lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(2));
        end
        if (p_wr) mem[p_addr] = p_wdata;
      end
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (pend) begin
        if (pend_lat == 0) begin
          avm_readdatavalid = 1'b1; avm_readdata = pend_data; pend = 0;
        end else pend_lat--;
      end else if (spur_en && $urandom_range(3) == 0) avm_readdatavalid = 1'b1;
      if (avm_read || avm_write) begin
        if (!in_txn) begin
          in_txn = 1;
          wleft = (forced_wait >= 0) ? forced_wait : int'($urandom_range(3));
        end
        if (stuck) w = 1;
        else if (wleft > 0) begin w = 1; wleft--; end
        else w = 0;
      end else begin
        in_txn = 0;
        w = 1'($urandom_range(1));
      end
      avm_waitrequest = w;
      p_rd = avm_read; p_wr = avm_write; p_wait = w;
      p_addr = avm_address; p_wdata = avm_writedata;
    end
  end

  // ---------------- Monitor / scoreboard ----------------
  initial begin
    logic prev_rdy;
    res_t r;
    wr_t  wx;
    prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      chk("strobe_exclusive", {63'd0, avm_read & avm_write}, 64'd0);
      if (!reset && avm_write && !avm_waitrequest) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", avm_address, avm_writedata);
        end else begin
          wx = wq.pop_front();
          chk("wr_addr", avm_address, wx.addr);
          chk("wr_data", avm_writedata, wx.data);
        end
      end
      if (!reset && monitor_ready && !prev_rdy) begin
        if (rq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready: MonDReg 0x%0h addr 0x%0h", MonDReg, avm_address);
        end else begin
          r = rq.pop_front();
          chk("res_mondreg", MonDReg, r.mon);
          chk("res_addr", avm_address, r.addr);
          chk("res_error", monitor_error, r.err);
        end
      end
      prev_rdy = monitor_ready;
    end
  end

  // ---------------- Reference model ----------------
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return AW'((int'(a) + 1) % (1 << AW));
  endfunction

  task automatic push_result();
    res_t r;
    r.mon = ref_mon; r.addr = ref_addr; r.err = ref_err;
    rq.push_back(r);
  endtask

  task automatic model_read(input bit tmo);
    if (tmo) ref_err = 1'b1;
    else begin
      ref_mon  = ref_mem[ref_addr];
      ref_addr = next_addr(ref_addr);
    end
    push_result();
  endtask

  task automatic pulse(input bit a, input bit b, input bit na, input logic [37:0] j);
    @(posedge clk); #1;
    ta_a = a; ta_b = b; tna = na; jdo = j;
    @(posedge clk); #1;
    ta_a = 0; ta_b = 0; tna = 0; jdo = 38'({$urandom, $urandom});
  endtask

  task automatic op(input bit a, input bit b, input bit na, input bit rden,
                    input logic [AW-1:0] ad, input logic [31:0] d, input bit tmo);
    logic [37:0] j;
    wr_t w;
    j = 38'({$urandom, $urandom});
    if (a) begin j[24:17] = ad; j[35] = rden; end
    else if (b) j[34:3] = d;
    if (a) begin
      ref_addr = ad;
      ref_err  = b | na;
      if (rden) model_read(tmo);
    end else if (b) begin
      if (na) ref_err = 1'b1;
      w.addr = ref_addr; w.data = d;
      wq.push_back(w);
      ref_mem[ref_addr] = d;
      ref_addr = next_addr(ref_addr);
      push_result();
    end else if (na) model_read(tmo);
    pulse(a, b, na, j);
  endtask

  task automatic run(output int nrd, output int nwr);
    nrd = 0; nwr = 0;
    #2;
    for (int n = 0; n < 600; n++) begin
      if (monitor_ready) break;
      nrd += int'(avm_read);
      nwr += int'(avm_write);
      @(posedge clk); #3;
    end
    checks++;
    if (!monitor_ready) begin
      failures++;
      $display("FAIL ready_wait: monitor_ready 0 after 600 cycles, required 1");
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- Stimulus ----------------
  initial begin
    int nrd, nwr, k;
    logic [31:0] mon_before;
    bit a, b, na;
    for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end

    repeat (3) @(posedge clk);
    #3;
    chk("rst_ready", monitor_ready, 1);
    chk("rst_mondreg", MonDReg, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_error", monitor_error, 0);
    reset = 0;

    // zero-wait read: cycle-exact latency
    forced_wait = 0; forced_lat = 0; spur_en = 0;
    mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    op(1, 0, 0, 1, 8'h10, 32'h0, 0);
    #2;
    chk("lat_n1_read", avm_read, 1);
    chk("lat_n1_addr", avm_address, 8'h10);
    @(posedge clk); #3;
    chk("lat_n2_busy", monitor_ready, 0);
    chk("lat_n2_rdv", avm_readdatavalid, 1);
    @(posedge clk); #3;
    chk("lat_n3_ready", monitor_ready, 1);
    chk("lat_n3_mondreg", MonDReg, 32'hDEADBEEF);
    chk("lat_n3_addr", avm_address, 8'h11);

    // write at top address with 3 wait cycles, address wraps
    op(1, 0, 0, 0, 8'hFF, 32'h0, 0);
    run(nrd, nwr);
    forced_wait = 3;
    op(0, 1, 0, 0, 8'h0, 32'h12345678, 0);
    run(nrd, nwr);
    chk("wr_strobe_cycles", nwr, 4);
    chk("wr_wrap_addr", avm_address, 8'h00);
    chk("wr_wdata_held", avm_writedata, 32'h12345678);

    // simultaneous write + no_action: write only, error set
    forced_wait = -1; spur_en = 1;
    op(0, 1, 1, 0, 8'h0, $urandom, 0);
    run(nrd, nwr);
    chk("simul_error", monitor_error, 1);
    op(1, 0, 0, 0, 8'h40, 32'h0, 0);
    run(nrd, nwr);
    chk("ocimem_a_clears_error", monitor_error, 0);

    // no_action pulse while busy writing
    forced_wait = 3;
    ref_err = 1'b1;
    op(0, 1, 0, 0, 8'h0, $urandom, 0);
    pulse(0, 0, 1, 38'({$urandom, $urandom}));
    run(nrd, nwr);
    chk("busy_drop_error", monitor_error, 1);

    // read with waitrequest stuck high: watchdog exit
    stuck = 1; forced_wait = -1;
    mon_before = ref_mon;
    op(0, 0, 1, 0, 8'h0, 32'h0, 1);
    run(nrd, nwr);
    chk("tmo_read_cycles", nrd, 255);
    chk("tmo_mondreg_kept", MonDReg, mon_before);
    stuck = 0;

    // reset while waiting for read data; late readdatavalid must be ignored
    repeat (2) @(posedge clk);
    forced_wait = 0; forced_lat = 3; spur_en = 0;
    pulse(0, 0, 1, 38'({$urandom, $urandom}));
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #3;
    chk("midrst_read", avm_read, 0);
    chk("midrst_ready", monitor_ready, 1);
    chk("midrst_mondreg", MonDReg, 0);
    chk("midrst_addr", avm_address, 0);
    @(posedge clk); #1; reset = 0;
    ref_addr = '0; ref_mon = '0; ref_err = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("late_rdv_mondreg", MonDReg, 0);
    chk("late_rdv_addr", avm_address, 0);
    chk("late_rdv_ready", monitor_ready, 1);

    // randomized command mix
    forced_wait = -1; forced_lat = -1; spur_en = 1;
    for (int i = 0; i < 80; i++) begin
      k  = int'($urandom_range(9));
      a  = (k < 4) || (k == 9);
      b  = (k == 4) || (k == 5) || (k == 8);
      na = (k >= 6);
      op(a, b, na, k != 3, AW'($urandom), $urandom, 0);
      run(nrd, nwr);
      repeat ($urandom_range(2)) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    chk("pending_results", rq.size(), 0);
    chk("pending_writes", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
